// File: rtl/hex_counter_display_ctrl_if.sv
// Switch/button inputs and display/count outputs of the hex counter display controller.
// master drives the controls and reads the display; slave is the controller itself.
interface hex_counter_display_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  wrap;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, up, load, load_val,
        input  count, tick, wrap, seg, an
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tick, wrap, seg, an
    );
endinterface

// File: rtl/hex_counter_display_ctrl.sv
// Prescaled up/down hex counter with load, driving a time-multiplexed active-low 7-segment display.
// Latency: count/tick/wrap one cycle after the tick or load cycle; seg/an one cycle behind count.
// No backpressure: inputs are sampled every cycle and all outputs are registered.
module hex_counter_display_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int SCAN_DIV = 1000,
    parameter int LZ_BLANK = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    hex_counter_display_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     psc_q;
    logic [W-1:0]      cnt_q;
    logic              tick_q;
    logic              wrap_q;
    logic [SW-1:0]     scan_q;
    logic [DW-1:0]     dig_q;
    logic [DW-1:0]     dig_nxt;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;
    logic              step;
    logic              wraps;
    logic              scan_end;
    logic [W-1:0]      upper;
    logic              blank;

    function automatic logic [6:0] seg_enc(input logic [3:0] n);
        case (n)
            4'h0: seg_enc = 7'h40;  4'h1: seg_enc = 7'h79;
            4'h2: seg_enc = 7'h24;  4'h3: seg_enc = 7'h30;
            4'h4: seg_enc = 7'h19;  4'h5: seg_enc = 7'h12;
            4'h6: seg_enc = 7'h02;  4'h7: seg_enc = 7'h78;
            4'h8: seg_enc = 7'h00;  4'h9: seg_enc = 7'h10;
            4'hA: seg_enc = 7'h08;  4'hB: seg_enc = 7'h03;
            4'hC: seg_enc = 7'h46;  4'hD: seg_enc = 7'h21;
            4'hE: seg_enc = 7'h06;  default: seg_enc = 7'h0E;
        endcase
    endfunction

    always_comb begin
        step     = bus.en && (psc_q == PW'(PRESCALE - 1));
        wraps    = bus.up ? (cnt_q == '1) : (cnt_q == '0);
        scan_end = (scan_q == SW'(SCAN_DIV - 1));
        dig_nxt  = dig_q;
        if (scan_end) begin
            dig_nxt = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + DW'(1);
        end
        // Nibbles at and above the digit about to be shown; all-zero means a leading zero.
        upper = cnt_q >> {dig_nxt, 2'b00};
        blank = (LZ_BLANK != 0) && (dig_nxt != '0) && (upper == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            psc_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            cnt_q  <= bus.load_val;
            psc_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= step;
            wrap_q <= step && wraps;
            if (step) begin
                psc_q <= '0;
                cnt_q <= bus.up ? cnt_q + W'(1) : cnt_q - W'(1);
            end else if (bus.en) begin
                psc_q <= psc_q + PW'(1);
            end
        end
    end

    // an and seg both come from dig_nxt on the same edge, so a digit never shows its neighbour's segments.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_q <= '0;
            dig_q  <= '0;
            an_q   <= ~DIGITS'(1);
            seg_q  <= 7'h40;
        end else begin
            scan_q <= scan_end ? '0 : scan_q + SW'(1);
            dig_q  <= dig_nxt;
            an_q   <= ~(DIGITS'(1) << dig_nxt);
            seg_q  <= blank ? 7'h7F : seg_enc(upper[3:0]);
        end
    end

    assign bus.count = cnt_q;
    assign bus.tick  = tick_q;
    assign bus.wrap  = wrap_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;
endmodule

// File: tb/tb_hex_counter_display_ctrl.sv
// Bench for hex_counter_display_ctrl with DIGITS=4, PRESCALE=4, SCAN_DIV=2, LZ_BLANK=1.
// Expected tick results are queued by the stimulus and consumed by a monitor on each tick pulse.
module tb_hex_counter_display_ctrl;
    localparam int DIGITS = 4;

    typedef struct packed {
        logic [15:0] count;
        logic        wrap;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    hex_counter_display_ctrl_if #(.DIGITS(DIGITS)) bus ();

    hex_counter_display_ctrl #(
        .DIGITS(DIGITS), .PRESCALE(4), .SCAN_DIV(2), .LZ_BLANK(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_an(input logic [3:0] want, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.an === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // Scoreboard monitor: every tick pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset !== 1'b1) begin
            if (bus.wrap === 1'b1) check("wrap_with_tick", bus.tick, 1);
            if (bus.tick === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got tick with count %h, none expected", bus.count);
                end else begin
                    e = sb.pop_front();
                    check("tick_count", bus.count, e.count);
                    check("tick_wrap", bus.wrap, e.wrap);
                end
            end else if (bus.tick !== 1'b0) begin
                check("tick_known", bus.tick, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] an_walk [9];
        logic [6:0] seg_walk [9];
        logic [6:0] scan_seg [4];
        logic       ok;

        an_walk  = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};
        seg_walk = '{7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        scan_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        reset = 1'b1;
        cyc(3);
        check("rst_count", bus.count, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_wrap", bus.wrap, 0);
        check("rst_an", bus.an, 4'hE);
        check("rst_seg", bus.seg, 7'h40);
        reset = 1'b0;

        // Idle scan with en low: digit 0 shows 0, leading zeros blanked.
        for (int k = 1; k < 9; k++) begin
            cyc(1);
            check("idle_an", bus.an, an_walk[k]);
            check("idle_seg", bus.seg, seg_walk[k]);
            check("idle_count", bus.count, 0);
        end

        // Up count: 16 ticks, one every 4 cycles.
        bus.en = 1'b1; bus.up = 1'b1;
        for (int i = 1; i <= 16; i++) sb.push_back('{16'(i), 1'b0});
        cyc(64);
        bus.en = 1'b0;
        cyc(1);
        check("up_drain", sb.size(), 0);
        check("up_count", bus.count, 16'h0010);
        wait_an(4'hD, ok);
        check("up_an_D_found", ok, 1);
        check("up_seg_digit1", bus.seg, 7'h79);

        // Up wrap from FFFE.
        bus.load = 1'b1; bus.load_val = 16'hFFFE;
        cyc(1);
        bus.load = 1'b0;
        check("load_count", bus.count, 16'hFFFE);
        check("load_tick", bus.tick, 0);
        bus.en = 1'b1;
        sb.push_back('{16'hFFFF, 1'b0});
        sb.push_back('{16'h0000, 1'b1});
        cyc(8);
        bus.en = 1'b0;
        cyc(1);
        check("upwrap_wrap_clear", bus.wrap, 0);
        check("upwrap_drain", sb.size(), 0);

        // Down wrap, then direction change with the prescaler at 2.
        bus.load = 1'b1; bus.load_val = 16'h0001;
        cyc(1);
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b0;
        sb.push_back('{16'h0000, 1'b0});
        sb.push_back('{16'hFFFF, 1'b1});
        cyc(10);
        bus.up = 1'b1;
        sb.push_back('{16'h0000, 1'b1});
        cyc(1);
        check("dir_no_early_tick", bus.tick, 0);
        cyc(1);
        check("dir_tick_kept_phase", bus.tick, 1);
        bus.en = 1'b0;
        cyc(1);
        check("down_drain", sb.size(), 0);

        // Load coincident with a tick cycle.
        bus.en = 1'b1; bus.up = 1'b1;
        sb.push_back('{16'h0001, 1'b0});
        cyc(7);
        bus.load = 1'b1; bus.load_val = 16'h1234;
        cyc(1);
        bus.load = 1'b0;
        check("collide_count", bus.count, 16'h1234);
        check("collide_tick", bus.tick, 0);
        check("collide_wrap", bus.wrap, 0);
        sb.push_back('{16'h1235, 1'b0});
        cyc(3);
        check("collide_no_early_tick", bus.tick, 0);
        cyc(1);
        check("collide_next_tick", bus.tick, 1);
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 16'h1234;
        cyc(1);
        bus.load = 1'b0;
        cyc(1);
        check("collide_drain", sb.size(), 0);
        for (int d = 0; d < 4; d++) begin
            wait_an(~(4'b0001 << d), ok);
            check("scan_an_found", ok, 1);
            check("scan_seg", bus.seg, scan_seg[d]);
        end

        // Enable pause with the prescaler at 2.
        bus.en = 1'b1;
        cyc(2);
        bus.en = 1'b0;
        cyc(10);
        check("pause_count_hold", bus.count, 16'h1234);
        check("pause_no_tick", bus.tick, 0);
        bus.en = 1'b1;
        sb.push_back('{16'h1235, 1'b0});
        cyc(1);
        check("resume_no_early_tick", bus.tick, 0);
        cyc(1);
        check("resume_tick", bus.tick, 1);
        bus.en = 1'b0;

        // Single-cycle reset in the middle of a scan dwell.
        cyc(3);
        reset = 1'b1;
        cyc(1);
        check("rst2_count", bus.count, 0);
        check("rst2_tick", bus.tick, 0);
        check("rst2_wrap", bus.wrap, 0);
        check("rst2_an", bus.an, 4'hE);
        check("rst2_seg", bus.seg, 7'h40);
        reset = 1'b0;
        cyc(1);
        check("rst2_dwell_an", bus.an, 4'hE);
        cyc(1);
        check("rst2_next_an", bus.an, 4'hD);

        cyc(2);
        check("final_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
